// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   - state_t      : FSM state encoding
//   - OP_* / FN_*  : opcode (IR[31:26]) and R-type funct (IR[5:0]) values
//   - ALU_*        : ALUCtrl encodings
//   - SRCA_*/SRCB_*: ALU operand select encodings
//   - IORD_*       : memory address select encodings
//   - PCS_*        : PC source select encodings
//   - DS_*         : register write-data select encodings
//   - REGDST_*     : destination register select encodings
//   - EXC_*        : exception cause codes
// Build option: MULTDIV_EN adds the multiply/divide states and constants.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
`ifdef MULTDIV_EN
    S_MD_START,
    S_MD_WAIT,
    S_MD_WB,
`endif
    S_EXC1,
    S_EXC2,
    S_EXC3,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
`ifdef MULTDIV_EN
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
`endif

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_A      = 2'b01;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;
  localparam logic [1:0] IORD_VEC    = 2'b10;

  localparam logic [1:0] PCS_ALU     = 2'b00;
  localparam logic [1:0] PCS_ALUOUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP    = 2'b10;
  localparam logic [1:0] PCS_MDR     = 2'b11;

  localparam logic [1:0] DS_ALUOUT   = 2'b00;
  localparam logic [1:0] DS_MDR      = 2'b01;
`ifdef MULTDIV_EN
  localparam logic [1:0] DS_HILO     = 2'b10;
`endif

  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;

  localparam logic [1:0] EXC_OPCODE  = 2'b00;
  localparam logic [1:0] EXC_OVF     = 2'b01;
`ifdef MULTDIV_EN
  localparam logic [1:0] EXC_DIV0    = 2'b10;
`endif

endpackage

// File: rtl/ctrl_wait_cnt.sv
// ---------------------------------------------------------------------------
// ctrl_wait_cnt
// 3-bit memory wait-state counter. Counts while enabled, clears on request
// and flags the last wait cycle (count == MEM_WAIT-1).
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   i_clear : return count to zero (state change)
//   i_en    : advance count this cycle
//   o_tc    : terminal count, high on the final wait cycle
// ---------------------------------------------------------------------------
module ctrl_wait_cnt #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [2:0] r_cnt;

  // Clear wins over counting so every new state starts its wait from zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Terminal value is one below the latency, so a wait lasts MEM_WAIT cycles.
  assign o_tc = (r_cnt == 3'(MEM_WAIT - 1));

endmodule

// File: rtl/ctrl_unit_mc.sv
// ---------------------------------------------------------------------------
// ctrl_unit_mc
// Multicycle control FSM for the MIPS-subset datapath. Moore decoder of the
// state and wait counter (BRANCH PC_Write is the single Mealy output).
// Build option: define MULTDIV_EN to include the multiply/divide handshake.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_Eq, i_Ofw           : ALU equality / overflow flags
//   i_OPCODE, i_FUNCT     : instruction fields from IR
//   i_md_done, i_md_div0  : mult/div unit completion and divide-by-zero
//   o_PC_Write .. o_EPC_Write : datapath selects and write enables
//   o_md_start, o_md_op   : mult/div start pulse and operation
//   o_exc_code            : cause of the most recent exception
//   o_reset_out, o_halted : datapath reset, halt indicator
// ---------------------------------------------------------------------------
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 2,
  parameter int unsigned EXC_ADDR_W = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_Eq,
  input  logic                  i_Ofw,
  input  logic [5:0]            i_OPCODE,
  input  logic [5:0]            i_FUNCT,
  input  logic                  i_md_done,
  input  logic                  i_md_div0,
  output logic                  o_PC_Write,
  output logic [1:0]            o_IorD,
  output logic                  o_MEM_write_or_read,
  output logic                  o_IR_Write,
  output logic [1:0]            o_RegDst,
  output logic                  o_RegWrite,
  output logic                  o_AB_Write,
  output logic [1:0]            o_ALUSrcA,
  output logic [1:0]            o_ALUSrcB,
  output logic [2:0]            o_ALUCtrl,
  output logic                  o_ALUOut_Write,
  output logic [1:0]            o_PCSource,
  output logic [1:0]            o_DataSrc,
  output logic                  o_EPC_Write,
  output logic                  o_md_start,
  output logic                  o_md_op,
  output logic [EXC_ADDR_W-1:0] o_exc_code,
  output logic                  o_reset_out,
  output logic                  o_halted
);

  state_t                r_state;
  state_t                w_next;
  logic [EXC_ADDR_W-1:0] r_exc_code;
  logic [EXC_ADDR_W-1:0] w_exc_sel;
  logic                  w_cnt_en;
  logic                  w_tc;
  logic                  w_clear;

`ifndef MULTDIV_EN
  logic w_unused_md;
  assign w_unused_md = i_md_done | i_md_div0;
`endif

  assign w_clear    = (w_next != r_state);
  assign o_exc_code = r_exc_code;

  ctrl_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  // State register; reset overrides any in-progress wait or handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // The cause is captured only on the transition into EXC1 and then held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exc_code <= '0;
    end else if (w_next == S_EXC1) begin
      r_exc_code <= w_exc_sel;
    end
  end

  // Next-state and output decode; everything defaults to idle first.
  always_comb begin
    w_next              = r_state;
    w_exc_sel           = EXC_ADDR_W'(EXC_OPCODE);
    w_cnt_en            = 1'b0;
    o_PC_Write          = 1'b0;
    o_IorD              = IORD_PC;
    o_MEM_write_or_read = 1'b0;
    o_IR_Write          = 1'b0;
    o_RegDst            = REGDST_RT;
    o_RegWrite          = 1'b0;
    o_AB_Write          = 1'b0;
    o_ALUSrcA           = SRCA_PC;
    o_ALUSrcB           = SRCB_B;
    o_ALUCtrl           = ALU_PASSA;
    o_ALUOut_Write      = 1'b0;
    o_PCSource          = PCS_ALU;
    o_DataSrc           = DS_ALUOUT;
    o_EPC_Write         = 1'b0;
    o_md_start          = 1'b0;
    o_md_op             = 1'b0;
    o_reset_out         = 1'b0;
    o_halted            = 1'b0;
    case (r_state)
      S_RESET: begin
        o_reset_out = 1'b1;
        w_next      = S_FETCH;
      end
      S_FETCH: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          o_IR_Write = 1'b1;
          o_PC_Write = 1'b1;
          o_ALUSrcA  = SRCA_PC;
          o_ALUSrcB  = SRCB_FOUR;
          o_ALUCtrl  = ALU_ADD;
          o_PCSource = PCS_ALU;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is dispatched.
        o_AB_Write     = 1'b1;
        o_ALUOut_Write = 1'b1;
        o_ALUSrcA      = SRCA_PC;
        o_ALUSrcB      = SRCB_IMM_SH;
        o_ALUCtrl      = ALU_ADD;
        case (i_OPCODE)
          OP_RTYPE: begin
            case (i_FUNCT)
              FN_ADD, FN_SUB, FN_AND: w_next = S_EXEC_R;
`ifdef MULTDIV_EN
              FN_MULT, FN_DIV:        w_next = S_MD_START;
`endif
              default:                w_next = S_EXC1;
            endcase
          end
          OP_ADDI:      w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_HALT:      w_next = S_HALT;
          default:      w_next = S_EXC1;
        endcase
      end
      S_EXEC_R: begin
        o_ALUSrcA      = SRCA_A;
        o_ALUSrcB      = SRCB_B;
        o_ALUOut_Write = 1'b1;
        if (i_FUNCT == FN_SUB) begin
          o_ALUCtrl = ALU_SUB;
        end else if (i_FUNCT == FN_AND) begin
          o_ALUCtrl = ALU_AND;
        end else begin
          o_ALUCtrl = ALU_ADD;
        end
        // AND cannot overflow, so the flag is ignored for it.
        if (i_Ofw && (i_FUNCT != FN_AND)) begin
          w_exc_sel = EXC_ADDR_W'(EXC_OVF);
          w_next    = S_EXC1;
        end else begin
          w_next = S_WB;
        end
      end
      S_EXEC_I: begin
        o_ALUSrcA      = SRCA_A;
        o_ALUSrcB      = SRCB_IMM;
        o_ALUCtrl      = ALU_ADD;
        o_ALUOut_Write = 1'b1;
        if (i_Ofw) begin
          w_exc_sel = EXC_ADDR_W'(EXC_OVF);
          w_next    = S_EXC1;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        o_RegWrite = 1'b1;
        o_DataSrc  = DS_ALUOUT;
        o_RegDst   = (i_OPCODE == OP_RTYPE) ? REGDST_RD : REGDST_RT;
        w_next     = S_FETCH;
      end
      S_MEM_ADDR: begin
        o_ALUSrcA      = SRCA_A;
        o_ALUSrcB      = SRCB_IMM;
        o_ALUCtrl      = ALU_ADD;
        o_ALUOut_Write = 1'b1;
        w_next         = (i_OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        o_IorD   = IORD_ALUOUT;
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        o_DataSrc  = DS_MDR;
        o_RegDst   = REGDST_RT;
        o_RegWrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        o_IorD              = IORD_ALUOUT;
        o_MEM_write_or_read = 1'b1;
        w_next              = S_FETCH;
      end
      S_BRANCH: begin
        o_ALUSrcA  = SRCA_A;
        o_ALUSrcB  = SRCB_B;
        o_ALUCtrl  = ALU_CMP;
        o_PCSource = PCS_ALUOUT;
        o_PC_Write = (i_OPCODE == OP_BNE) ? !i_Eq : i_Eq;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        o_PCSource = PCS_JUMP;
        o_PC_Write = 1'b1;
        w_next     = S_FETCH;
      end
`ifdef MULTDIV_EN
      S_MD_START: begin
        o_md_start = 1'b1;
        o_md_op    = (i_FUNCT == FN_DIV);
        w_next     = S_MD_WAIT;
      end
      S_MD_WAIT: begin
        // md_div0 only has meaning in the cycle md_done is high.
        if (i_md_done) begin
          if (i_md_div0) begin
            w_exc_sel = EXC_ADDR_W'(EXC_DIV0);
            w_next    = S_EXC1;
          end else begin
            w_next = S_MD_WB;
          end
        end
      end
      S_MD_WB: begin
        o_RegWrite = 1'b1;
        o_DataSrc  = DS_HILO;
        o_RegDst   = REGDST_RD;
        w_next     = S_FETCH;
      end
`endif
      S_EXC1: begin
        // PC already points past the faulting instruction; EPC gets PC-4.
        o_EPC_Write = 1'b1;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_FOUR;
        o_ALUCtrl   = ALU_SUB;
        w_next      = S_EXC2;
      end
      S_EXC2: begin
        o_IorD   = IORD_VEC;
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_next = S_EXC3;
        end
      end
      S_EXC3: begin
        o_PCSource = PCS_MDR;
        o_PC_Write = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      default: begin
        w_next = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_ctrl_unit_mc
// Self-checking bench for ctrl_unit_mc with MEM_WAIT=2. Each cycle the
// expected full output vector is queued when inputs are driven and compared
// against the DUT a little after the falling edge.
// ---------------------------------------------------------------------------
module tb_ctrl_unit_mc;

  localparam int unsigned MW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Eq = 1'b0;
  logic       Ofw = 1'b0;
  logic [5:0] OPCODE = 6'h00;
  logic [5:0] FUNCT = 6'h00;
  logic       md_done = 1'b0;
  logic       md_div0 = 1'b0;

  logic       PC_Write, MEM_write_or_read, IR_Write, RegWrite, AB_Write;
  logic       ALUOut_Write, EPC_Write, md_start, md_op, reset_out, halted;
  logic [1:0] IorD, RegDst, ALUSrcA, ALUSrcB, PCSource, DataSrc, exc_code;
  logic [2:0] ALUCtrl;

  typedef struct packed {
    logic       pcw;
    logic [1:0] iord;
    logic       mwr;
    logic       irw;
    logic [1:0] regdst;
    logic       regw;
    logic       abw;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       aluoutw;
    logic [1:0] pcsrc;
    logic [1:0] dsrc;
    logic       epcw;
    logic       mdstart;
    logic       mdop;
    logic [1:0] exc;
    logic       rstout;
    logic       halted;
  } ov_t;

  ov_t   actual;
  ov_t   expQ[$];
  string tagQ[$];
  logic [1:0] expExc = 2'b00;
  int    nChecks = 0;
  int    nErrors = 0;

  ctrl_unit_mc #(.MEM_WAIT(MW), .EXC_ADDR_W(2)) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_Eq                (Eq),
    .i_Ofw               (Ofw),
    .i_OPCODE            (OPCODE),
    .i_FUNCT             (FUNCT),
    .i_md_done           (md_done),
    .i_md_div0           (md_div0),
    .o_PC_Write          (PC_Write),
    .o_IorD              (IorD),
    .o_MEM_write_or_read (MEM_write_or_read),
    .o_IR_Write          (IR_Write),
    .o_RegDst            (RegDst),
    .o_RegWrite          (RegWrite),
    .o_AB_Write          (AB_Write),
    .o_ALUSrcA           (ALUSrcA),
    .o_ALUSrcB           (ALUSrcB),
    .o_ALUCtrl           (ALUCtrl),
    .o_ALUOut_Write      (ALUOut_Write),
    .o_PCSource          (PCSource),
    .o_DataSrc           (DataSrc),
    .o_EPC_Write         (EPC_Write),
    .o_md_start          (md_start),
    .o_md_op             (md_op),
    .o_exc_code          (exc_code),
    .o_reset_out         (reset_out),
    .o_halted            (halted)
  );

  always #5 clk = ~clk;

  // Gather the DUT outputs into one vector for whole-cycle comparison.
  always_comb begin
    actual.pcw     = PC_Write;
    actual.iord    = IorD;
    actual.mwr     = MEM_write_or_read;
    actual.irw     = IR_Write;
    actual.regdst  = RegDst;
    actual.regw    = RegWrite;
    actual.abw     = AB_Write;
    actual.srca    = ALUSrcA;
    actual.srcb    = ALUSrcB;
    actual.alu     = ALUCtrl;
    actual.aluoutw = ALUOut_Write;
    actual.pcsrc   = PCSource;
    actual.dsrc    = DataSrc;
    actual.epcw    = EPC_Write;
    actual.mdstart = md_start;
    actual.mdop    = md_op;
    actual.exc     = exc_code;
    actual.rstout  = reset_out;
    actual.halted  = halted;
  end

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs for this cycle are already driven; queue the expectation and advance.
  task automatic applyStimulus(input string tag, input ov_t e);
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(negedge clk);
  endtask

  // Pop one expectation per cycle, sampled mid low phase.
  always @(negedge clk) begin
    ov_t   e;
    string t;
    #2;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(t, 32'(actual), 32'(e));
    end
  end

  function automatic ov_t vBase();
    ov_t v = '0;
    v.exc = expExc;
    return v;
  endfunction

  function automatic ov_t vRst();
    ov_t v = vBase();
    v.rstout = 1'b1;
    return v;
  endfunction

  function automatic ov_t vFetch(input logic last);
    ov_t v = vBase();
    if (last) begin
      v.irw = 1'b1; v.pcw = 1'b1; v.srcb = 2'b01; v.alu = 3'b001;
    end
    return v;
  endfunction

  function automatic ov_t vDecode();
    ov_t v = vBase();
    v.abw = 1'b1; v.aluoutw = 1'b1; v.srcb = 2'b11; v.alu = 3'b001;
    return v;
  endfunction

  function automatic ov_t vExec(input logic [1:0] srcb, input logic [2:0] alu);
    ov_t v = vBase();
    v.srca = 2'b01; v.srcb = srcb; v.alu = alu; v.aluoutw = 1'b1;
    return v;
  endfunction

  function automatic ov_t vRegWb(input logic [1:0] dsrc, input logic [1:0] regdst);
    ov_t v = vBase();
    v.regw = 1'b1; v.dsrc = dsrc; v.regdst = regdst;
    return v;
  endfunction

  function automatic ov_t vMem(input logic [1:0] iord, input logic wr);
    ov_t v = vBase();
    v.iord = iord; v.mwr = wr;
    return v;
  endfunction

  function automatic ov_t vBranch(input logic pcw);
    ov_t v = vBase();
    v.srca = 2'b01; v.alu = 3'b111; v.pcsrc = 2'b01; v.pcw = pcw;
    return v;
  endfunction

  function automatic ov_t vPcLoad(input logic [1:0] pcsrc);
    ov_t v = vBase();
    v.pcsrc = pcsrc; v.pcw = 1'b1;
    return v;
  endfunction

  function automatic ov_t vExc1();
    ov_t v = vBase();
    v.epcw = 1'b1; v.srcb = 2'b01; v.alu = 3'b010;
    return v;
  endfunction

  function automatic ov_t vFlag(input logic mdstart, input logic mdop, input logic hlt);
    ov_t v = vBase();
    v.mdstart = mdstart; v.mdop = mdop; v.halted = hlt;
    return v;
  endfunction

  task automatic fetchDecode();
    for (int i = 0; i < int'(MW); i++) applyStimulus("FETCH", vFetch(i == int'(MW) - 1));
    applyStimulus("DECODE", vDecode());
  endtask

  task automatic excSeq(input logic [1:0] code);
    expExc = code;
    applyStimulus("EXC1", vExc1());
    for (int i = 0; i < int'(MW); i++) applyStimulus("EXC2", vMem(2'b10, 1'b0));
    applyStimulus("EXC3", vPcLoad(2'b11));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset high for three rising edges, then one extra RESET cycle.
    @(negedge clk);
    applyStimulus("RST_held", vRst());
    applyStimulus("RST_held", vRst());
    reset = 1'b0;
    applyStimulus("RST_post", vRst());

    // ADD, SUB, AND (overflow flag ignored for AND)
    OPCODE = 6'h00; FUNCT = 6'h20;
    fetchDecode();
    applyStimulus("EXEC_R_add", vExec(2'b00, 3'b001));
    applyStimulus("WB_R", vRegWb(2'b00, 2'b01));
    FUNCT = 6'h22;
    fetchDecode();
    applyStimulus("EXEC_R_sub", vExec(2'b00, 3'b010));
    applyStimulus("WB_R", vRegWb(2'b00, 2'b01));
    FUNCT = 6'h24;
    fetchDecode();
    Ofw = 1'b1;
    applyStimulus("EXEC_R_and", vExec(2'b00, 3'b011));
    Ofw = 1'b0;
    applyStimulus("WB_R_and", vRegWb(2'b00, 2'b01));

    // ADDI without and with overflow
    OPCODE = 6'h08;
    fetchDecode();
    applyStimulus("EXEC_I", vExec(2'b10, 3'b001));
    applyStimulus("WB_I", vRegWb(2'b00, 2'b00));
    fetchDecode();
    Ofw = 1'b1;
    applyStimulus("EXEC_I_ovf", vExec(2'b10, 3'b001));
    Ofw = 1'b0;
    excSeq(2'b01);

    // DIV with divide-by-zero after a long wait
    OPCODE = 6'h00; FUNCT = 6'h1A;
`ifdef MULTDIV_EN
    fetchDecode();
    applyStimulus("MD_START_div", vFlag(1'b1, 1'b1, 1'b0));
    md_div0 = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus("MD_WAIT", vBase());
    md_done = 1'b1;
    applyStimulus("MD_WAIT_done", vBase());
    md_done = 1'b0; md_div0 = 1'b0;
    excSeq(2'b10);
    FUNCT = 6'h18;
    fetchDecode();
    applyStimulus("MD_START_mult", vFlag(1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) applyStimulus("MD_WAIT", vBase());
    md_done = 1'b1;
    applyStimulus("MD_WAIT_done", vBase());
    md_done = 1'b0;
    applyStimulus("MD_WB", vRegWb(2'b10, 2'b01));
`else
    md_done = 1'b1; md_div0 = 1'b1;
    fetchDecode();
    md_done = 1'b0; md_div0 = 1'b0;
    excSeq(2'b00);
`endif

    // Undefined opcode
    OPCODE = 6'h10;
    fetchDecode();
    excSeq(2'b00);

    // LW and SW
    OPCODE = 6'h23;
    fetchDecode();
    applyStimulus("MEM_ADDR_lw", vExec(2'b10, 3'b001));
    for (int i = 0; i < int'(MW); i++) applyStimulus("MEM_RD", vMem(2'b01, 1'b0));
    applyStimulus("MEM_WB", vRegWb(2'b01, 2'b00));
    OPCODE = 6'h2B;
    fetchDecode();
    applyStimulus("MEM_ADDR_sw", vExec(2'b10, 3'b001));
    applyStimulus("MEM_WR", vMem(2'b01, 1'b1));

    // BEQ/BNE with both Eq values
    for (int i = 0; i < 4; i++) begin
      OPCODE = (i < 2) ? 6'h04 : 6'h05;
      fetchDecode();
      Eq = 1'(i % 2);
      applyStimulus((i < 2) ? "BRANCH_beq" : "BRANCH_bne", vBranch((i < 2) ? Eq : !Eq));
      Eq = 1'b0;
    end

    // Jump
    OPCODE = 6'h02;
    fetchDecode();
    applyStimulus("JUMP", vPcLoad(2'b10));

    // LW interrupted by reset in its second read cycle
    OPCODE = 6'h23;
    fetchDecode();
    applyStimulus("MEM_ADDR_lw", vExec(2'b10, 3'b001));
    applyStimulus("MEM_RD_1", vMem(2'b01, 1'b0));
    reset = 1'b1;
    applyStimulus("MEM_RD_2_rst", vMem(2'b01, 1'b0));
    expExc = 2'b00;
    applyStimulus("RST_from_lw", vRst());
    reset = 1'b0;
    applyStimulus("RST_post", vRst());

    // HALT holds regardless of inputs until reset
    OPCODE = 6'h3F;
    fetchDecode();
    md_done = 1'b1; Eq = 1'b1; Ofw = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("HALT", vFlag(1'b0, 1'b0, 1'b1));
    md_done = 1'b0; Eq = 1'b0; Ofw = 1'b0;
    reset = 1'b1;
    applyStimulus("HALT_rst", vFlag(1'b0, 1'b0, 1'b1));
    applyStimulus("RST_from_halt", vRst());
    reset = 1'b0;
    applyStimulus("RST_post", vRst());
    OPCODE = 6'h00; FUNCT = 6'h20;
    fetchDecode();

    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
